// File: rtl/dcache_wt_controller_pkg.sv
// Shared encodings for the write-through data cache: FSM states and store-size codes.
// The store-size codes match the control unit's store field.
package dcache_wt_controller_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RD_MISS = 2'b01,
        S_REFILL  = 2'b10,
        S_WR_MEM  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ST_SW = 2'b00,
        ST_SH = 2'b01,
        ST_SB = 2'b10
    } store_size_e;

    // Code 11 falls into the default and behaves as a full-word store.
    // Bit 0 of the address is ignored for halfword stores.
    function automatic logic [3:0] store_byte_en(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            ST_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
            ST_SB:   be = 4'b0001 << lane;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dcache_wt_controller_if.sv
// Control-unit / memory side bus of the data-cache controller.
// master = pipeline + memory environment, slave = the cache controller.
interface dcache_wt_controller_if #(parameter int ADDR_W = 10);
    logic              mem_read;
    logic              mem_write;
    logic [1:0]        store;
    logic [ADDR_W-1:0] addr;
    logic              stall;
    logic              hit;
    logic              cache_we;
    logic              cache_refill;
    logic [3:0]        byte_en;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;

    modport master (
        output mem_read, mem_write, store, addr, mem_ready,
        input  stall, hit, cache_we, cache_refill, byte_en, mem_rd_req, mem_wr_req, mem_addr
    );

    modport slave (
        input  mem_read, mem_write, store, addr, mem_ready,
        output stall, hit, cache_we, cache_refill, byte_en, mem_rd_req, mem_wr_req, mem_addr
    );
endinterface

// File: rtl/dcache_wt_controller_tag_valid_array.sv
// Direct-mapped tag/valid store: combinational read, single write port, valid bits async-cleared.
// Tags are left unreset; a line is only trusted once its valid bit is set.
module dcache_wt_controller_tag_valid_array #(
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic [TAG_W-1:0]   rd_tag,
    output logic               rd_valid,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);
    localparam int LINES = 2 ** INDEX_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_tag   = tag_q[rd_index];
    assign rd_valid = valid_q[rd_index];
endmodule

// File: rtl/dcache_wt_controller.sv
// Write-through, no-write-allocate data-cache controller: FSM, hit compare, byte-lane decode.
// Load hit is zero-latency; misses and all stores stall the pipeline until mem_ready.
module dcache_wt_controller
    import dcache_wt_controller_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int INDEX_W   = 4,
    parameter int WORDS_BLK = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dcache_wt_controller_if.slave  bus
);
    localparam int OFFSET_W = $clog2(WORDS_BLK) + 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    state_e state_q, state_d;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [TAG_W-1:0]   line_tag;
    logic               line_valid;
    logic               lookup_hit;
    logic               tv_we;

    assign addr_tag   = bus.addr[ADDR_W-1 -: TAG_W];
    assign addr_index = bus.addr[OFFSET_W +: INDEX_W];
    assign lookup_hit = line_valid && (line_tag == addr_tag);

    dcache_wt_controller_tag_valid_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_valid (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (addr_index),
        .rd_tag   (line_tag),
        .rd_valid (line_valid),
        .wr_en    (tv_we),
        .wr_index (addr_index),
        .wr_tag   (addr_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are gated by rst_n so an in-flight request drops the moment reset asserts.
    always_comb begin
        state_d          = state_q;
        bus.stall        = 1'b0;
        bus.hit          = 1'b0;
        bus.cache_we     = 1'b0;
        bus.cache_refill = 1'b0;
        bus.byte_en      = 4'b0000;
        bus.mem_rd_req   = 1'b0;
        bus.mem_wr_req   = 1'b0;
        bus.mem_addr     = '0;
        tv_we            = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_write) begin
                        bus.hit   = lookup_hit;
                        bus.stall = 1'b1;
                        state_d   = S_WR_MEM;
                    end else if (bus.mem_read) begin
                        bus.hit = lookup_hit;
                        if (!lookup_hit) begin
                            bus.stall = 1'b1;
                            state_d   = S_RD_MISS;
                        end
                    end
                end
                S_RD_MISS: begin
                    bus.hit        = lookup_hit;
                    bus.stall      = 1'b1;
                    bus.mem_rd_req = 1'b1;
                    bus.mem_addr   = {addr_tag, addr_index, {OFFSET_W{1'b0}}};
                    if (bus.mem_ready) begin
                        state_d = S_REFILL;
                    end
                end
                S_REFILL: begin
                    bus.hit          = lookup_hit;
                    bus.stall        = 1'b1;
                    bus.cache_refill = 1'b1;
                    tv_we            = 1'b1;
                    state_d          = S_IDLE;
                end
                S_WR_MEM: begin
                    bus.hit        = lookup_hit;
                    bus.mem_wr_req = 1'b1;
                    bus.mem_addr   = bus.addr;
                    bus.byte_en    = store_byte_en(bus.store, bus.addr[1:0]);
                    // Releasing stall in the ack cycle lets the store retire on this edge.
                    if (bus.mem_ready) begin
                        bus.cache_we = lookup_hit;
                        state_d      = S_IDLE;
                    end else begin
                        bus.stall = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wt_controller.sv
// Randomized + directed bench for dcache_wt_controller against a transaction-level cache model.
module tb_dcache_wt_controller;

    logic clk;
    logic rst_n;

    dcache_wt_controller_if #(.ADDR_W(10)) bus ();

    dcache_wt_controller #(.ADDR_W(10), .INDEX_W(4), .WORDS_BLK(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       stall;
        logic       hit;
        logic       we;
        logic       refill;
        logic [3:0] be;
        logic       rd;
        logic       wr;
        logic [9:0] ma;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the tag store: 16 lines, 2-bit tags.
    bit       m_valid [16];
    bit [1:0] m_tag   [16];

    // DUT observations captured during a transaction for literal pinning.
    bit         saw_rd;
    bit         saw_we;
    logic [9:0] last_rd_addr;
    logic [3:0] last_be;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
        end
    endtask

    // Compare all outputs in the middle of the cycle, then advance to just after the next edge.
    task automatic cyc(input string nm, input exp_t e);
        @(negedge clk);
        chk({nm, ".stall"},  32'(bus.stall),        32'(e.stall));
        chk({nm, ".hit"},    32'(bus.hit),          32'(e.hit));
        chk({nm, ".we"},     32'(bus.cache_we),     32'(e.we));
        chk({nm, ".refill"}, 32'(bus.cache_refill), 32'(e.refill));
        chk({nm, ".be"},     32'(bus.byte_en),      32'(e.be));
        chk({nm, ".rd"},     32'(bus.mem_rd_req),   32'(e.rd));
        chk({nm, ".wr"},     32'(bus.mem_wr_req),   32'(e.wr));
        chk({nm, ".maddr"},  32'(bus.mem_addr),     32'(e.ma));
        if (bus.mem_rd_req) begin saw_rd = 1'b1; last_rd_addr = bus.mem_addr; end
        if (bus.mem_wr_req) last_be = bus.byte_en;
        if (bus.cache_we)   saw_we = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input logic [9:0] a);
        int idx = int'(a) / 16 % 16;
        return m_valid[idx] && (m_tag[idx] == 2'(int'(a) / 256));
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [9:0] a);
        int lane = int'(a) % 4;
        if (size == 2'b10) return 4'(1 << lane);
        if (size == 2'b01) return (lane >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic clear_obs();
        saw_rd = 1'b0; saw_we = 1'b0; last_rd_addr = '0; last_be = '0;
    endtask

    task automatic idle_cycle(input bit stray_ready);
        exp_t e = '0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_ready = stray_ready;
        cyc("idle", e);
        bus.mem_ready = 1'b0;
    endtask

    // A load: a hit costs one cycle; a miss costs 1 + lat + 1 stalled cycles, then hits.
    task automatic do_load(input logic [9:0] a, input int lat);
        exp_t e = '0;
        int idx = int'(a) / 16 % 16;
        bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.addr = a; bus.store = 2'($urandom_range(0, 3));
        if (model_hit(a)) begin
            e.hit = 1'b1;
            cyc("ld_hit", e);
        end else begin
            e.stall = 1'b1;
            cyc("ld_miss", e);
            for (int i = 1; i <= lat; i++) begin
                e = '0; e.stall = 1'b1; e.rd = 1'b1; e.ma = (a / 16) * 16;
                bus.mem_ready = (i == lat);
                cyc("ld_rdreq", e);
            end
            bus.mem_ready = 1'b0;
            e = '0; e.stall = 1'b1; e.refill = 1'b1;
            cyc("ld_refill", e);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = 2'(int'(a) / 256);
            e = '0; e.hit = 1'b1;
            cyc("ld_after", e);
        end
        bus.mem_read = 1'b0;
    endtask

    // A store: one request cycle, lat cycles of mem_wr_req; ack cycle releases stall.
    task automatic do_store(input logic [9:0] a, input logic [1:0] size, input int lat, input bit also_read);
        exp_t e = '0;
        bit h = model_hit(a);
        bus.mem_write = 1'b1; bus.mem_read = also_read; bus.addr = a; bus.store = size;
        e.stall = 1'b1; e.hit = h;
        cyc("st_req", e);
        for (int i = 1; i <= lat; i++) begin
            e = '0; e.hit = h; e.wr = 1'b1; e.ma = a; e.be = model_be(size, a);
            e.stall = (i != lat); e.we = (i == lat) && h;
            bus.mem_ready = (i == lat);
            cyc("st_wrreq", e);
        end
        bus.mem_ready = 1'b0; bus.mem_write = 1'b0; bus.mem_read = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst_n = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.store = 2'b00;
        bus.addr = '0; bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_tag[i] = '0; end
        clear_obs();

        // Reset state, with a request presented: everything must stay low.
        bus.mem_read = 1'b1; bus.addr = 10'h040;
        e = '0;
        cyc("reset", e);
        bus.mem_read = 1'b0;
        rst_n = 1'b1;
        idle_cycle(1'b0);

        // Test 1: first load misses; 3-cycle memory.
        clear_obs();
        do_load(10'h040, 3);
        chk("t1_miss", 32'(saw_rd), 32'd1);
        chk("t1_rd_addr", 32'(last_rd_addr), 32'h040);
        idle_cycle(1'b0);

        // Test 2: same block hits.
        clear_obs();
        do_load(10'h044, 3);
        chk("t2_no_req", 32'(saw_rd), 32'd0);

        // Test 3: SB to a hit line.
        clear_obs();
        do_store(10'h046, 2'b10, 2, 1'b0);
        chk("t3_be", 32'(last_be), 32'h4);
        chk("t3_we", 32'(saw_we), 32'd1);
        idle_cycle(1'b0);

        // Test 4: SW miss does not allocate.
        clear_obs();
        do_store(10'h300, 2'b00, 1, 1'b0);
        chk("t4_we", 32'(saw_we), 32'd0);
        clear_obs();
        do_load(10'h300, 2);
        chk("t4_ld_miss", 32'(saw_rd), 32'd1);

        // Test 5: conflict at index 4 between tags 0 and 1.
        clear_obs(); do_load(10'h140, 1); chk("t5_a", 32'(saw_rd), 32'd1);
        clear_obs(); do_load(10'h040, 2); chk("t5_b", 32'(saw_rd), 32'd1);
        clear_obs(); do_load(10'h140, 1); chk("t5_c", 32'(saw_rd), 32'd1);
        clear_obs(); do_load(10'h040, 4); chk("t5_d", 32'(saw_rd), 32'd1);

        // Stray mem_ready while idle is ignored.
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // Test 6: reset during RD_MISS.
        bus.mem_read = 1'b1; bus.addr = 10'h0a0;
        e = '0; e.stall = 1'b1;
        cyc("t6_req", e);
        e = '0; e.stall = 1'b1; e.rd = 1'b1; e.ma = 10'h0a0;
        cyc("t6_rdreq", e);
        rst_n = 1'b0;
        #1;
        chk("t6_rd_drop", 32'(bus.mem_rd_req), 32'd0);
        chk("t6_stall_drop", 32'(bus.stall), 32'd0);
        bus.mem_read = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        clear_obs();
        do_load(10'h0a0, 2);
        chk("t6_miss_again", 32'(saw_rd), 32'd1);

        // Randomized traffic over a small address window to mix hits, misses and conflicts.
        for (int n = 0; n < 150; n++) begin
            logic [9:0] a;
            int kind = $urandom_range(0, 9);
            int lat  = $urandom_range(1, 4);
            a = {2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
            if (kind < 5)       do_load(a, lat);
            else if (kind < 8)  do_store(a, 2'($urandom_range(0, 3)), lat, 1'b0);
            else if (kind == 8) do_store(a, 2'($urandom_range(0, 3)), lat, 1'b1);
            else                idle_cycle($urandom_range(0, 1) == 1);
        end
        idle_cycle(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
